// File: rtl/rx_uart_pkg.sv
// Shared constants and FSM state encodings for the UART receive path.
package rx_uart_pkg;

    localparam int DATA_W           = 8;
    localparam int BPS_CNT_W        = 13;
    localparam int CLKS_PER_BIT_DEF = 5208;
    localparam int HALF_BIT_DEF     = CLKS_PER_BIT_DEF / 2;

    typedef logic [2:0] rx_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/rx_uart_module_bps.sv
// Receive bit-rate counter: free-runs while Count_Sig is high and flags the
// mid-bit sample point once per bit period.
module rx_bps_module
    import rx_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic Count_Sig,
    output logic BPS_CLK
);

    localparam logic [BPS_CNT_W-1:0] LAST_CNT = BPS_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BPS_CNT_W-1:0] HALF_CNT = BPS_CNT_W'(HALF_BIT);

    logic [BPS_CNT_W-1:0] count_bps_q;
    logic [BPS_CNT_W-1:0] count_bps_d;

    always_comb begin
        count_bps_d = '0;
        if (Count_Sig) begin
            if (count_bps_q == LAST_CNT) begin
                count_bps_d = '0;
            end else begin
                count_bps_d = count_bps_q + BPS_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_bps_q <= '0;
        end else begin
            count_bps_q <= count_bps_d;
        end
    end

    assign BPS_CLK = (count_bps_q == HALF_CNT);

endmodule

// File: rtl/rx_uart_module.sv
// UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined): synchronizes the
// RX pin, samples each bit at mid-bit and strobes out the received byte.
module rx_uart_module
    import rx_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_En_Sig,
    input  logic              RX_Pin_In,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Done_Sig,
    output logic              Frame_Err,
    output logic              Parity_Err
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    rx_state_t         state_q, state_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              stop_err_q, stop_err_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
    logic              par_bit_q, par_bit_d;
    logic              parity_err_q, parity_err_d;
`endif

    logic rx_s;
    logic fall_edge;
    logic count_sig;
    logic bps_clk;

    always_comb begin
        sync1_d = RX_Pin_In;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    assign rx_s      = sync2_q;
    assign fall_edge = hist_q & ~sync2_q;
    assign count_sig = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);

    rx_bps_module #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .HALF_BIT     (HALF_BIT)
    ) u_bps (
        .CLK       (CLK),
        .RST       (RST),
        .Count_Sig (count_sig),
        .BPS_CLK   (bps_clk)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_err_d  = stop_err_q;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        // Disable wins over everything, including the DONE output load.
        if (!RX_En_Sig) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_edge) state_d = ST_START;
                end
                ST_START: begin
                    if (bps_clk) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_idx_d = 3'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bps_clk) begin
                        shift_d[bit_idx_q] = rx_s;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (bps_clk) begin
                        par_bit_d = rx_s;
                        state_d   = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bps_clk) begin
                        stop_err_d = ~rx_s;
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    rx_data_d   = shift_q;
                    frame_err_d = stop_err_q;
`ifdef RX_PARITY_EN
                    parity_err_d = (^shift_q) != par_bit_q;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            state_q     <= ST_IDLE;
            bit_idx_q   <= 3'd0;
            stop_err_q  <= 1'b0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            stop_err_q  <= stop_err_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Frame assembly registers are fully rewritten every frame before use.
    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
`ifdef RX_PARITY_EN
        par_bit_q <= par_bit_d;
`endif
    end

    assign RX_Data     = rx_data_q;
    assign RX_Done_Sig = done_q;
    assign Frame_Err   = frame_err_q;
`ifdef RX_PARITY_EN
    assign Parity_Err  = parity_err_q;
`else
    assign Parity_Err  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_uart_module.sv
// Scoreboard bench for rx_uart_module at CLKS_PER_BIT=16.
module tb_rx_uart_module;

    localparam int C    = 16;
    localparam int HALF = C / 2;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Strobe visible this many edges after the stimulus edge preceding the start bit.
    localparam int LAT = 5 + HALF + 9 * C + (PAR_EN ? C : 0);

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_En_Sig = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       Frame_Err;
    logic       Parity_Err;

    rx_uart_module #(
        .CLKS_PER_BIT (C),
        .HALF_BIT     (HALF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_En_Sig   (RX_En_Sig),
        .RX_Pin_In   (RX_Pin_In),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .Frame_Err   (Frame_Err),
        .Parity_Err  (Parity_Err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         at;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST) begin
            if (RX_Done_Sig) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data",    int'(RX_Data),    int'(e.d));
                    chk("frame_err",  int'(Frame_Err),  int'(e.fe));
                    chk("parity_err", int'(Parity_Err), int'(e.pe));
                    chk("latency",    cyc,              e.at);
                end
            end else begin
                chk("idle_frame_err",  int'(Frame_Err),  0);
                chk("idle_parity_err", int'(Parity_Err), 0);
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX_Pin_In = b;
        hold(C);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit expect_strobe, input logic fe, input logic pe);
        exp_t e;
        if (expect_strobe) begin
            e.d  = d;
            e.fe = fe;
            e.pe = pe;
            e.at = cyc + LAT;
            sb.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"},    int'(RX_Data),     0);
        chk({tag, "_done"},       int'(RX_Done_Sig), 0);
        chk({tag, "_frame_err"},  int'(Frame_Err),   0);
        chk({tag, "_parity_err"}, int'(Parity_Err),  0);
    endtask

    initial begin
        logic [7:0] partial;
        partial = 8'hA5;

        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk_reset_outputs("reset");
        hold(2);

        // Basic frame with valid stop
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(2 * C);

        // Back-to-back frames without idle gap
        send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(2 * C);

        // Short low glitch must be rejected at the start-bit check
        RX_Pin_In = 1'b0;
        hold(3);
        RX_Pin_In = 1'b1;
        hold(3 * C);
        chk("glitch_rx_data_held", int'(RX_Data), 8'h0F);

        // Stop bit low, then line held low (break)
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(4 * C);
        RX_Pin_In = 1'b1;
        hold(2 * C);
        chk("break_rx_data_held", int'(RX_Data), 8'hFF);

        // Reset during data bit 4, then a clean frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        RX_Pin_In = partial[4];
        hold(C / 2);
        RST = 1'b1;
        RX_Pin_In = 1'b1;
        hold(1);
        RST = 1'b0;
        chk_reset_outputs("midframe_reset");
        hold(2 * C);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        hold(2 * C);

        // Enable dropped mid-frame: no strobe, data unchanged
        fork
            send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                hold(3 * C);
                RX_En_Sig = 1'b0;
            end
        join
        hold(2 * C);
        RX_En_Sig = 1'b1;
        hold(2 * C);
        chk("disable_rx_data_held", int'(RX_Data), 8'h3C);

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            hold(2 * C);
            send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            hold(2 * C);
        end

        hold(2 * C);
        chk("pending_strobes", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
